// File: rtl/blake_ctrl_pkg.sv
// Shared definitions for the BLAKE round sequencer.
// Contents: 2-bit state encodings, default step/round constants, and a
// clog2 helper that sizes the step-within-round index.
package blake_ctrl_pkg;

  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_WAIT_BLK = 2'd1;
  localparam logic [1:0] ST_ROUND    = 2'd2;
  localparam logic [1:0] ST_FIN      = 2'd3;

  localparam int unsigned BLAKE512_STEPS = 128;
  localparam int unsigned BLAKE_SPR      = 8;

  function automatic int unsigned clog2(input int unsigned value);
    int unsigned res;
    res = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(value)) res = i + 1;
    end
    return res;
  endfunction

endpackage

// File: rtl/blake_step_counter.sv
// Step counter for the BLAKE round sequencer.
// Ports:
//   clk, rstb  : clock, asynchronous active-low reset
//   clr        : synchronous clear to 0 (highest priority)
//   load       : load the finalise value NUM_STEPS-1
//   en         : increment by one
//   count      : current step count
//   tc         : count has reached the last round step (NUM_STEPS-2)
module blake_step_counter #(
  parameter int unsigned CNT_W     = 7,
  parameter int unsigned NUM_STEPS = 128
) (
  input  logic             clk,
  input  logic             rstb,
  input  logic             clr,
  input  logic             load,
  input  logic             en,
  output logic [CNT_W-1:0] count,
  output logic             tc
);

  localparam logic [CNT_W-1:0] TC_VAL  = CNT_W'(NUM_STEPS - 2);
  localparam logic [CNT_W-1:0] FIN_VAL = CNT_W'(NUM_STEPS - 1);

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb)      count <= '0;
    else if (clr)   count <= '0;
    else if (load)  count <= FIN_VAL;
    else if (en)    count <= count + CNT_W'(1);
  end

  assign tc = (count >= TC_VAL);

endmodule

// File: rtl/blake_round_ctrl.sv
// Moore-style round sequencer for the BLAKE compression core.
// Sequences V init, NUM_STEPS-1 round steps and a finalise step per message
// block, over nblk blocks delivered through a blk_valid/blk_ready handshake.
// Ports:
//   clk, rstb     : clock, asynchronous active-low reset
//   start, nblk   : start request (IDLE only) and block count (0 means 1)
//   blk_valid     : next message block available (WAIT_BLK only)
//   stall         : freeze stepping in ROUND
//   abort         : (BLAKE_CTRL_ABORT_EN only) return to IDLE immediately
//   blk_ready, init_round, round_ing, step_en, ctrl_finalize : phase strobes
//   counter_idx, round_idx, step_idx, blk_idx : step and block indices
//   busy, done    : not-idle flag, last-block finalise pulse
// Optional feature macro: BLAKE_CTRL_ABORT_EN adds the abort input.
module blake_round_ctrl
  import blake_ctrl_pkg::*;
#(
  parameter int unsigned CNT_W           = 7,
  parameter int unsigned NUM_STEPS       = BLAKE512_STEPS,
  parameter int unsigned STEPS_PER_ROUND = BLAKE_SPR,
  parameter int unsigned BLK_W           = 8,
  localparam int unsigned SPR_W          = clog2(STEPS_PER_ROUND)
) (
  input  logic                   clk,
  input  logic                   rstb,
  input  logic                   start,
  input  logic [BLK_W-1:0]       nblk,
  input  logic                   blk_valid,
  input  logic                   stall,
`ifdef BLAKE_CTRL_ABORT_EN
  input  logic                   abort,
`endif
  output logic                   blk_ready,
  output logic                   init_round,
  output logic                   round_ing,
  output logic                   step_en,
  output logic                   ctrl_finalize,
  output logic [CNT_W-1:0]       counter_idx,
  output logic [CNT_W-SPR_W-1:0] round_idx,
  output logic [SPR_W-1:0]       step_idx,
  output logic [BLK_W-1:0]       blk_idx,
  output logic                   busy,
  output logic                   done
);

  logic [1:0]       state, state_n;
  logic [BLK_W-1:0] nblk_q, nblk_n;
  logic [BLK_W-1:0] blk_n;
  logic             cnt_clr, cnt_load, cnt_en, cnt_tc;
  logic             last_blk;
  logic             abort_hit;

`ifdef BLAKE_CTRL_ABORT_EN
  assign abort_hit = abort && (state != ST_IDLE);
`else
  assign abort_hit = 1'b0;
`endif

  // nblk is stored already normalised (0 -> 1), so this compare cannot underflow
  // once a message is in flight.
  assign last_blk = (blk_idx == nblk_q - BLK_W'(1));

  always_comb begin
    state_n  = state;
    nblk_n   = nblk_q;
    blk_n    = blk_idx;
    cnt_clr  = 1'b0;
    cnt_load = 1'b0;
    cnt_en   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) begin
          nblk_n  = (nblk == '0) ? BLK_W'(1) : nblk;
          blk_n   = '0;
          state_n = ST_WAIT_BLK;
        end
      end
      ST_WAIT_BLK: begin
        if (blk_valid) begin
          cnt_clr = 1'b1;
          state_n = ST_ROUND;
        end
      end
      ST_ROUND: begin
        if (!stall) begin
          if (cnt_tc) begin
            cnt_load = 1'b1;
            state_n  = ST_FIN;
          end else begin
            cnt_en = 1'b1;
          end
        end
      end
      ST_FIN: begin
        cnt_clr = 1'b1;
        if (last_blk) begin
          state_n = ST_IDLE;
        end else begin
          blk_n   = blk_idx + BLK_W'(1);
          state_n = ST_WAIT_BLK;
        end
      end
      default: begin
        state_n = ST_IDLE;
        cnt_clr = 1'b1;
      end
    endcase
    if (abort_hit) begin
      state_n  = ST_IDLE;
      blk_n    = '0;
      cnt_clr  = 1'b1;
      cnt_load = 1'b0;
      cnt_en   = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state   <= ST_IDLE;
      nblk_q  <= '0;
      blk_idx <= '0;
    end else begin
      state   <= state_n;
      nblk_q  <= nblk_n;
      blk_idx <= blk_n;
    end
  end

  blake_step_counter #(
    .CNT_W     (CNT_W),
    .NUM_STEPS (NUM_STEPS)
  ) u_cnt (
    .clk   (clk),
    .rstb  (rstb),
    .clr   (cnt_clr),
    .load  (cnt_load),
    .en    (cnt_en),
    .count (counter_idx),
    .tc    (cnt_tc)
  );

  assign init_round    = (state == ST_WAIT_BLK) && blk_valid && !abort_hit;
  assign blk_ready     = init_round;
  assign round_ing     = (state == ST_ROUND);
  assign step_en       = round_ing && !stall;
  assign ctrl_finalize = (state == ST_FIN);
  assign done          = (state == ST_FIN) && last_blk && !abort_hit;
  assign busy          = (state != ST_IDLE);
  assign round_idx     = counter_idx[CNT_W-1:SPR_W];
  assign step_idx      = counter_idx[SPR_W-1:0];

endmodule

// File: tb/tb_blake_round_ctrl.sv
// Directed self-checking bench for blake_round_ctrl: a default-parameter
// instance (128 steps, 8 steps/round) and a 16-step, 4 steps/round instance.
module tb_blake_round_ctrl;

  // flag vector order: init_round, blk_ready, round_ing, step_en,
  //                    ctrl_finalize, done, busy
  localparam logic [6:0] F_IDLE  = 7'b0000000;
  localparam logic [6:0] F_WAIT  = 7'b0000001;
  localparam logic [6:0] F_INIT  = 7'b1100001;
  localparam logic [6:0] F_RUN   = 7'b0011001;
  localparam logic [6:0] F_STALL = 7'b0010001;
  localparam logic [6:0] F_FIN   = 7'b0000101;
  localparam logic [6:0] F_DONE  = 7'b0000111;

  logic       clk = 1'b0;
  logic       rstb, start, blk_valid, stall;
  logic [7:0] nblk;
`ifdef BLAKE_CTRL_ABORT_EN
  logic       abort;
`endif

  logic       blk_ready, init_round, round_ing, step_en, ctrl_finalize, busy, done;
  logic [6:0] counter_idx;
  logic [3:0] round_idx;
  logic [2:0] step_idx;
  logic [7:0] blk_idx;

  logic       start_s;
  logic [3:0] nblk_s;
  logic       s_blk_ready, s_init_round, s_round_ing, s_step_en, s_finalize, s_busy, s_done;
  logic [3:0] s_counter;
  logic [1:0] s_round_idx, s_step_idx;
  logic [3:0] s_blk_idx;

  logic [6:0] obs, s_obs;
  int total = 0;
  int bad   = 0;

  assign obs   = {init_round, blk_ready, round_ing, step_en, ctrl_finalize, done, busy};
  assign s_obs = {s_init_round, s_blk_ready, s_round_ing, s_step_en, s_finalize, s_done, s_busy};

  always #5 clk = ~clk;

  blake_round_ctrl dut (
    .clk(clk), .rstb(rstb), .start(start), .nblk(nblk),
    .blk_valid(blk_valid), .stall(stall),
`ifdef BLAKE_CTRL_ABORT_EN
    .abort(abort),
`endif
    .blk_ready(blk_ready), .init_round(init_round), .round_ing(round_ing),
    .step_en(step_en), .ctrl_finalize(ctrl_finalize), .counter_idx(counter_idx),
    .round_idx(round_idx), .step_idx(step_idx), .blk_idx(blk_idx),
    .busy(busy), .done(done)
  );

  blake_round_ctrl #(
    .CNT_W(4), .NUM_STEPS(16), .STEPS_PER_ROUND(4), .BLK_W(4)
  ) dut_s (
    .clk(clk), .rstb(rstb), .start(start_s), .nblk(nblk_s),
    .blk_valid(blk_valid), .stall(stall),
`ifdef BLAKE_CTRL_ABORT_EN
    .abort(abort),
`endif
    .blk_ready(s_blk_ready), .init_round(s_init_round), .round_ing(s_round_ing),
    .step_en(s_step_en), .ctrl_finalize(s_finalize), .counter_idx(s_counter),
    .round_idx(s_round_idx), .step_idx(s_step_idx), .blk_idx(s_blk_idx),
    .busy(s_busy), .done(s_done)
  );

  task automatic test_reset();
    rstb = 1'b0; start = 1'b0; nblk = 8'd0; blk_valid = 1'b0; stall = 1'b0;
    start_s = 1'b0; nblk_s = 4'd1;
`ifdef BLAKE_CTRL_ABORT_EN
    abort = 1'b0;
`endif
    #3;
    total++;
    if ({obs, counter_idx, round_idx, step_idx, blk_idx} !== 29'd0) begin
      bad++;
      $display("FAIL reset main got=%b/%0d/%0d want=0", obs, counter_idx, blk_idx);
    end
    total++;
    if ({s_obs, s_counter, s_blk_idx} !== 15'd0) begin
      bad++;
      $display("FAIL reset small got=%b/%0d want=0", s_obs, s_counter);
    end
    @(negedge clk);
    rstb = 1'b1;
    @(negedge clk);
    #1;
    total++;
    if ({obs, counter_idx} !== {F_IDLE, 7'd0}) begin
      bad++;
      $display("FAIL reset_release got=%b/%0d want=%b/0", obs, counter_idx, F_IDLE);
    end
  endtask

  task automatic test_single();
    logic [6:0] ef, ec;
    for (int c = 0; c <= 130; c++) begin
      @(negedge clk);
      start = (c == 0); nblk = 8'd1; blk_valid = 1'b1; stall = 1'b0;
      #1;
      if (c == 0)        begin ef = F_IDLE; ec = 7'd0; end
      else if (c == 1)   begin ef = F_INIT; ec = 7'd0; end
      else if (c <= 128) begin ef = F_RUN;  ec = 7'(c - 2); end
      else if (c == 129) begin ef = F_DONE; ec = 7'd127; end
      else               begin ef = F_IDLE; ec = 7'd0; end
      total++;
      if ({obs, counter_idx} !== {ef, ec}) begin
        bad++;
        $display("FAIL single c=%0d got=%b/%0d want=%b/%0d", c, obs, counter_idx, ef, ec);
      end
      if (c == 129) begin
        total++;
        if ({round_idx, step_idx, blk_idx} !== {4'd15, 3'd7, 8'd0}) begin
          bad++;
          $display("FAIL single_fin_idx got=%0d/%0d/%0d want=15/7/0", round_idx, step_idx, blk_idx);
        end
      end
    end
  endtask

  task automatic test_multi();
    logic [6:0] ef, ec;
    logic [7:0] eb;
    int inits = 0, fins = 0, dones = 0, waits = 0, base;
    for (int c = 0; c <= 393; c++) begin
      @(negedge clk);
      start = (c == 0); nblk = 8'd3; stall = 1'b0;
      blk_valid = !(c >= 259 && c <= 263);
      #1;
      if (c == 0 || c == 393)                begin ef = F_IDLE; ec = 7'd0; end
      else if (c == 1 || c == 130 || c == 264) begin ef = F_INIT; ec = 7'd0; end
      else if (c >= 259 && c <= 263)         begin ef = F_WAIT; ec = 7'd0; end
      else if (c == 129 || c == 258)         begin ef = F_FIN;  ec = 7'd127; end
      else if (c == 392)                     begin ef = F_DONE; ec = 7'd127; end
      else begin
        base = (c < 129) ? 2 : (c < 258) ? 131 : 265;
        ef = F_RUN; ec = 7'(c - base);
      end
      eb = (c <= 129) ? 8'd0 : (c <= 258) ? 8'd1 : 8'd2;
      total++;
      if ({obs, counter_idx} !== {ef, ec}) begin
        bad++;
        $display("FAIL multi c=%0d got=%b/%0d want=%b/%0d", c, obs, counter_idx, ef, ec);
      end
      if (c >= 1 && c <= 392) begin
        total++;
        if (blk_idx !== eb) begin
          bad++;
          $display("FAIL multi_blk_idx c=%0d got=%0d want=%0d", c, blk_idx, eb);
        end
      end
      if (init_round) inits++;
      if (ctrl_finalize) fins++;
      if (done) dones++;
      if (obs === F_WAIT) waits++;
    end
    total++;
    if ({inits, fins, dones, waits} !== {32'd3, 32'd3, 32'd1, 32'd5}) begin
      bad++;
      $display("FAIL multi_counts got init=%0d fin=%0d done=%0d wait=%0d want 3/3/1/5",
               inits, fins, dones, waits);
    end
  endtask

  task automatic test_stall();
    logic [6:0] ef, ec;
    for (int c = 0; c <= 140; c++) begin
      @(negedge clk);
      start = (c == 0); nblk = 8'd1; blk_valid = 1'b1;
      stall = (c >= 39 && c <= 48);
      #1;
      if (c == 0)                    begin ef = F_IDLE;  ec = 7'd0; end
      else if (c == 1)               begin ef = F_INIT;  ec = 7'd0; end
      else if (c <= 38)              begin ef = F_RUN;   ec = 7'(c - 2); end
      else if (c <= 48)              begin ef = F_STALL; ec = 7'd37; end
      else if (c <= 138)             begin ef = F_RUN;   ec = 7'(c - 12); end
      else if (c == 139)             begin ef = F_DONE;  ec = 7'd127; end
      else                           begin ef = F_IDLE;  ec = 7'd0; end
      total++;
      if ({obs, counter_idx} !== {ef, ec}) begin
        bad++;
        $display("FAIL stall c=%0d got=%b/%0d want=%b/%0d", c, obs, counter_idx, ef, ec);
      end
      if (c == 39) begin
        total++;
        if ({round_idx, step_idx} !== {4'd4, 3'd5}) begin
          bad++;
          $display("FAIL decode_37 got=%0d/%0d want=4/5", round_idx, step_idx);
        end
      end
    end
  endtask

  task automatic test_start_ignored_nblk0();
    logic [6:0] ef, ec;
    for (int c = 0; c <= 131; c++) begin
      @(negedge clk);
      start = (c == 0 || c == 50);
      nblk  = (c == 50) ? 8'd5 : 8'd0;
      blk_valid = 1'b1;
      stall = (c == 129);
      #1;
      if (c == 0)        begin ef = F_IDLE; ec = 7'd0; end
      else if (c == 1)   begin ef = F_INIT; ec = 7'd0; end
      else if (c <= 128) begin ef = F_RUN;  ec = 7'(c - 2); end
      else if (c == 129) begin ef = F_DONE; ec = 7'd127; end
      else               begin ef = F_IDLE; ec = 7'd0; end
      total++;
      if ({obs, counter_idx} !== {ef, ec}) begin
        bad++;
        $display("FAIL nblk0 c=%0d got=%b/%0d want=%b/%0d", c, obs, counter_idx, ef, ec);
      end
    end
    stall = 1'b0;
  endtask

  task automatic test_small();
    logic [6:0] ef;
    logic [3:0] ec;
    for (int c = 0; c <= 18; c++) begin
      @(negedge clk);
      start_s = (c == 0); nblk_s = 4'd1; blk_valid = 1'b1; stall = 1'b0;
      #1;
      if (c == 0)       begin ef = F_IDLE; ec = 4'd0; end
      else if (c == 1)  begin ef = F_INIT; ec = 4'd0; end
      else if (c <= 16) begin ef = F_RUN;  ec = 4'(c - 2); end
      else if (c == 17) begin ef = F_DONE; ec = 4'd15; end
      else              begin ef = F_IDLE; ec = 4'd0; end
      total++;
      if ({s_obs, s_counter} !== {ef, ec}) begin
        bad++;
        $display("FAIL small c=%0d got=%b/%0d want=%b/%0d", c, s_obs, s_counter, ef, ec);
      end
      if (c == 10 || c == 17) begin
        total++;
        if ({s_round_idx, s_step_idx} !== ((c == 10) ? 4'b1000 : 4'b1111)) begin
          bad++;
          $display("FAIL small_decode c=%0d got=%0d/%0d", c, s_round_idx, s_step_idx);
        end
      end
    end
    start_s = 1'b0;
  endtask

  task automatic test_async_reset();
    for (int c = 0; c <= 62; c++) begin
      @(negedge clk);
      start = (c == 0); nblk = 8'd1; blk_valid = 1'b1; stall = 1'b0;
    end
    #1;
    total++;
    if ({obs, counter_idx} !== {F_RUN, 7'd60}) begin
      bad++;
      $display("FAIL areset_pre got=%b/%0d want=%b/60", obs, counter_idx, F_RUN);
    end
    #2 rstb = 1'b0;
    #1;
    total++;
    if ({obs, counter_idx, round_idx, step_idx, blk_idx} !== 29'd0) begin
      bad++;
      $display("FAIL areset_immediate got=%b/%0d want=0", obs, counter_idx);
    end
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      #1;
      total++;
      if ({obs, counter_idx} !== 14'd0) begin
        bad++;
        $display("FAIL areset_hold c=%0d got=%b/%0d want=0", c, obs, counter_idx);
      end
    end
    @(negedge clk);
    rstb = 1'b1;
    @(negedge clk);
    #1;
    total++;
    if ({obs, counter_idx} !== {F_IDLE, 7'd0}) begin
      bad++;
      $display("FAIL areset_after got=%b/%0d want=%b/0", obs, counter_idx, F_IDLE);
    end
  endtask

`ifdef BLAKE_CTRL_ABORT_EN
  task automatic test_abort();
    logic [6:0] ef, ec;
    for (int c = 0; c <= 130; c++) begin
      @(negedge clk);
      start = (c == 0); abort = (c == 0 || c == 129);
      nblk = 8'd1; blk_valid = 1'b1; stall = 1'b0;
      #1;
      if (c == 0)        begin ef = F_IDLE; ec = 7'd0; end
      else if (c == 1)   begin ef = F_INIT; ec = 7'd0; end
      else if (c <= 128) begin ef = F_RUN;  ec = 7'(c - 2); end
      else if (c == 129) begin ef = F_FIN;  ec = 7'd127; end
      else               begin ef = F_IDLE; ec = 7'd0; end
      total++;
      if ({obs, counter_idx} !== {ef, ec}) begin
        bad++;
        $display("FAIL abort c=%0d got=%b/%0d want=%b/%0d", c, obs, counter_idx, ef, ec);
      end
    end
    abort = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_multi();
    test_stall();
    test_start_ignored_nblk0();
    test_small();
    test_async_reset();
`ifdef BLAKE_CTRL_ABORT_EN
    test_abort();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
